// File: rtl/window_sum_multi_if.sv
// Stream interface for window_sum_multi.
//   din_*  : sample beats into the block (din_ready returned by the block).
//   dout_* : per-window result out of the block (dout_ready returned by the sink).
// Handshake rule for both directions: a transfer happens on a rising clk edge
// where valid && ready are both high. Once valid is raised, the payload is
// held stable until that transfer happens.
// The producer/sink side uses the master modport; the block uses slave.
interface window_sum_multi_if #(
  parameter int W_DATA = 26,
  parameter int N_CH   = 2
) ();
  logic                       din_valid;
  logic                       din_ready;
  logic [N_CH*W_DATA-1:0]     din_data;
  logic [1:0]                 din_eot;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [N_CH*(W_DATA+2)-1:0] dout_data;

  modport master (
    output din_valid, din_data, din_eot, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_data, din_eot, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/window_sum_multi.sv
// Multi-channel box sum from integral-image samples.
// A window is cfg_win_h rows of cfg_win_w beats, row-major. For each channel
// the result is D - B - C + A, where A/B/C/D are the top-left, top-right,
// bottom-left and bottom-right samples of the window, computed modulo
// 2^(W_DATA+2).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   cfg_win_w/h        : window size, latched on a window's first beat
//                        (0 -> 1, above maximum -> maximum)
//   bus (slave)        : din_* sample stream in, dout_* result stream out
//   err_eot            : one-cycle pulse after a beat with wrong din_eot framing
//   dbg_state          : 1 while a window is partially accumulated
module window_sum_multi #(
  parameter int W_DATA    = 26,
  parameter int N_CH      = 2,
  parameter int MAX_WIN_W = 24,
  parameter int MAX_WIN_H = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_WIN_W+1)-1:0] cfg_win_w,
  input  logic [$clog2(MAX_WIN_H+1)-1:0] cfg_win_h,
  window_sum_multi_if.slave              bus,
  output logic                           err_eot,
  output logic                           dbg_state
);
  localparam int CW = $clog2(MAX_WIN_W+1);
  localparam int HW = $clog2(MAX_WIN_H+1);
  localparam int AW = W_DATA + 2;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        col_q, col_n, w_q, w_n, w_cl, cur_w;
  logic [HW-1:0]        row_q, row_n, h_q, h_n, h_cl, cur_h;
  logic [AW-1:0]        acc_q [N_CH];
  logic [AW-1:0]        acc_n [N_CH];
  logic [AW-1:0]        acc_sum [N_CH];
  logic [AW-1:0]        smp;
  logic                 dout_valid_q, dout_valid_n;
  logic [N_CH*AW-1:0]   dout_data_q, dout_data_n;
  logic                 err_n;
  logic                 din_ready;
  logic                 accept, last_col, last_row, frame_err, final_beat;
  logic                 c_a, c_b, c_c, c_d;

  assign din_ready      = !dout_valid_q || bus.dout_ready;
  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign dbg_state      = (state_q == ACCUM);

  always_comb begin
    w_cl = (cfg_win_w == '0) ? CW'(1) :
           (cfg_win_w > CW'(MAX_WIN_W)) ? CW'(MAX_WIN_W) : cfg_win_w;
    h_cl = (cfg_win_h == '0) ? HW'(1) :
           (cfg_win_h > HW'(MAX_WIN_H)) ? HW'(MAX_WIN_H) : cfg_win_h;
    // In IDLE the beat on the bus is the window's first, so live cfg applies.
    cur_w = (state_q == IDLE) ? w_cl : w_q;
    cur_h = (state_q == IDLE) ? h_cl : h_q;

    accept     = bus.din_valid && din_ready;
    last_col   = (col_q == cur_w - CW'(1));
    last_row   = (row_q == cur_h - HW'(1));
    frame_err  = accept && ((bus.din_eot[0] != last_col) ||
                            (bus.din_eot[1] != (last_col && last_row)));
    final_beat = accept && !frame_err && last_col && last_row;

    // Corner membership; coinciding corners cancel when w=1 or h=1.
    c_a = (row_q == '0) && (col_q == '0);
    c_b = (row_q == '0) && last_col;
    c_c = last_row && (col_q == '0);
    c_d = last_row && last_col;

    smp = '0;
    for (int k = 0; k < N_CH; k++) begin
      smp        = {2'b00, bus.din_data[k*W_DATA +: W_DATA]};
      acc_sum[k] = acc_q[k] + (c_a ? smp : '0) - (c_b ? smp : '0)
                            - (c_c ? smp : '0) + (c_d ? smp : '0);
    end

    state_n     = state_q;
    col_n       = col_q;
    row_n       = row_q;
    w_n         = w_q;
    h_n         = h_q;
    acc_n       = acc_q;
    dout_data_n = dout_data_q;
    err_n       = frame_err;

    if (accept) begin
      if (frame_err || final_beat) begin
        state_n = IDLE;
        col_n   = '0;
        row_n   = '0;
        for (int k = 0; k < N_CH; k++) acc_n[k] = '0;
        if (final_beat) begin
          for (int k = 0; k < N_CH; k++) dout_data_n[k*AW +: AW] = acc_sum[k];
        end
      end else begin
        state_n = ACCUM;
        w_n     = cur_w;
        h_n     = cur_h;
        acc_n   = acc_sum;
        if (last_col) begin
          col_n = '0;
          row_n = row_q + HW'(1);
        end else begin
          col_n = col_q + CW'(1);
        end
      end
    end

    dout_valid_n = final_beat ? 1'b1 : (bus.dout_ready ? 1'b0 : dout_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= CW'(1);
      h_q          <= HW'(1);
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      err_eot      <= 1'b0;
    end else begin
      state_q      <= state_n;
      col_q        <= col_n;
      row_q        <= row_n;
      w_q          <= w_n;
      h_q          <= h_n;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_n[k];
      dout_valid_q <= dout_valid_n;
      dout_data_q  <= dout_data_n;
      err_eot      <= err_n;
    end
  end
endmodule

// File: tb/tb_window_sum_multi.sv
module tb_window_sum_multi;
  localparam int W    = 26;
  localparam int NC   = 2;
  localparam int MAXW = 24;
  localparam int MAXH = 24;
  localparam int AW   = W + 2;
  localparam int CWB  = $clog2(MAXW+1);
  localparam int HWB  = $clog2(MAXH+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CWB-1:0] cfg_win_w = '0;
  logic [HWB-1:0] cfg_win_h = '0;
  logic           err_eot;
  logic           dbg_state;

  window_sum_multi_if #(.W_DATA(W), .N_CH(NC)) bus ();

  window_sum_multi #(.W_DATA(W), .N_CH(NC), .MAX_WIN_W(MAXW), .MAX_WIN_H(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_win_w (cfg_win_w),
    .cfg_win_h (cfg_win_h),
    .bus       (bus.slave),
    .err_eot   (err_eot),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [NC*AW-1:0] exp_q[$];
  int               errors = 0;
  int               checks = 0;
  int               exp_err = 0;
  int               err_seen = 0;
  int               ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
  bit               lat_pending = 0;
  logic [W-1:0]     samp [NC][MAXW*MAXH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int eff(input int raw, input int mx);
    if (raw == 0) return 1;
    if (raw > mx) return mx;
    return raw;
  endfunction

  // Reference: corner formula D - B - C + A taken directly from the samples.
  function automatic logic [NC*AW-1:0] model(input int w, input int h);
    logic [NC*AW-1:0] r;
    logic [AW-1:0]    a, b, c, d;
    r = '0;
    for (int k = 0; k < NC; k++) begin
      a = AW'(samp[k][0]);
      b = AW'(samp[k][w-1]);
      c = AW'(samp[k][(h-1)*w]);
      d = AW'(samp[k][h*w-1]);
      r[k*AW +: AW] = d - b - c + a;
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NC; k++)
      for (int i = 0; i < MAXW*MAXH; i++) samp[k][i] = W'($urandom);
  endtask

  // dout_ready driver
  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = 1'($urandom_range(0, 1));
        default: bus.dout_ready = 1'b0;
      endcase
    end
  end

  // one beat, held until accepted
  task automatic beat(input logic [NC*W-1:0] d, input logic [1:0] eot);
    bit done = 0;
    int t = 0;
    bus.din_valid = 1'b1;
    bus.din_data  = d;
    bus.din_eot   = eot;
    while (!done) begin
      @(negedge clk);
      done = bus.din_ready;
      @(posedge clk); #1;
      t++;
      if (!done && t > 300) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got no accept after %0d cycles expected accept", t);
        done = 1;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic run_window(input int raw_w, input int raw_h, input int err_beat,
                            input int abort_at, input bit gaps);
    int w, h, col, row;
    logic [NC*W-1:0] d;
    logic [1:0] eot;
    logic [31:0] rw, rh;
    w = eff(raw_w, MAXW);
    h = eff(raw_h, MAXH);
    rw = raw_w;
    rh = raw_h;
    cfg_win_w = rw[CWB-1:0];
    cfg_win_h = rh[HWB-1:0];
    if (err_beat >= 0) exp_err++;
    else if (abort_at < 0) exp_q.push_back(model(w, h));
    for (int i = 0; i < w*h; i++) begin
      if (i == abort_at) break;
      col = i % w;
      row = i / w;
      eot[0] = (col == w-1);
      eot[1] = (col == w-1) && (row == h-1);
      if (i == err_beat) eot[0] = ~eot[0];
      for (int k = 0; k < NC; k++) d[k*W +: W] = samp[k][i];
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.din_valid = 1'b0;
        @(posedge clk); #1;
      end
      beat(d, eot);
      if (i == 0) begin
        cfg_win_w = CWB'($urandom_range(0, 31));
        cfg_win_h = HWB'($urandom_range(0, 31));
      end
      if (i == err_beat) break;
    end
    if (err_beat < 0 && abort_at < 0) lat_pending = 1;
  endtask

  // monitor
  logic             hold_valid = 0;
  logic [NC*AW-1:0] hold_data;
  logic             err_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_valid = 0;
        err_prev   = 0;
        continue;
      end
      if (lat_pending) begin
        check("result_latency", 64'(bus.dout_valid), 64'd1);
        lat_pending = 0;
      end
      if (err_eot) begin
        err_seen++;
        if (err_prev) check("err_one_cycle", 64'(err_prev), 64'd0);
      end
      err_prev = err_eot;
      if (bus.dout_valid && hold_valid)
        check("dout_stable", 64'(bus.dout_data), 64'(hold_data));
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(bus.dout_data), 64'd0);
          if (bus.dout_data == '0) begin
            errors++;
            $display("FAIL unexpected_result: got a result expected none");
          end
        end else begin
          check("result", 64'(bus.dout_data), 64'(exp_q.pop_front()));
        end
        hold_valid = 0;
      end else if (bus.dout_valid) begin
        hold_valid = 1;
        hold_data  = bus.dout_data;
      end else begin
        hold_valid = 0;
      end
    end
  end

  // stimulus
  initial begin
    int w, h, eb;
    bus.din_valid = 1'b0;
    bus.din_data  = '0;
    bus.din_eot   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_din_ready", 64'(bus.din_ready), 64'd1);
    check("rst_err_eot", 64'(err_eot), 64'd0);
    check("rst_dout_data", 64'(bus.dout_data), 64'd0);
    @(posedge clk); #1;

    // 3x2 known corners: 100 - 30 - 50 + 10 = 30 on ch0
    fill_random();
    samp[0][0] = 10; samp[0][2] = 30; samp[0][3] = 50; samp[0][5] = 100;
    check("ref_3x2", 64'(model(3, 2) & {{(NC-1)*AW{1'b0}}, {AW{1'b1}}}), 64'd30);
    run_window(3, 2, -1, -1, 0);

    // degenerate windows give zero
    fill_random();
    samp[0][0] = 77; samp[1][0] = 77;
    run_window(1, 1, -1, -1, 0);
    fill_random();
    samp[0][0] = 5; samp[0][1] = 6; samp[0][2] = 7; samp[0][3] = 9;
    run_window(4, 1, -1, -1, 0);

    // full-size window with known ch1 corners, then back-to-back window
    fill_random();
    samp[1][0] = 0; samp[1][23] = 0; samp[1][552] = 0; samp[1][575] = 576;
    run_window(24, 24, -1, -1, 0);
    fill_random();
    run_window(24, 24, -1, -1, 0);

    // clamping of cfg: 0 -> 1, over max -> max
    fill_random();
    run_window(0, 0, -1, -1, 0);
    fill_random();
    run_window(31, 3, -1, -1, 0);

    // output stall: result held, input blocked, resumes on ready
    ready_mode = 2;
    @(posedge clk); #1;
    fill_random();
    run_window(3, 2, -1, -1, 0);
    fill_random();
    fork
      run_window(2, 2, -1, -1, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_din_ready", 64'(bus.din_ready), 64'd0);
          check("stall_dout_valid", 64'(bus.dout_valid), 64'd1);
        end
        ready_mode = 0;
        @(negedge clk);
        check("resume_din_ready", 64'(bus.din_ready), 64'd1);
        check("resume_dout_valid", 64'(bus.dout_valid), 64'd1);
      end
    join

    // framing error on col 1, then a clean window
    fill_random();
    run_window(3, 2, 1, -1, 0);
    fill_random();
    run_window(3, 2, -1, -1, 0);

    // reset after 10 beats of a 4x4 window
    fill_random();
    run_window(4, 4, -1, 10, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    end
    @(posedge clk); #1;
    fill_random();
    run_window(4, 4, -1, -1, 0);

    // randomized windows with random backpressure and occasional errors
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      w = $urandom_range(0, 31);
      h = $urandom_range(0, 5);
      eb = -1;
      if (eff(w, MAXW) * eff(h, MAXH) > 1 && $urandom_range(0, 4) == 0)
        eb = $urandom_range(1, eff(w, MAXW) * eff(h, MAXH) - 1);
      fill_random();
      run_window(w, h, eb, -1, 1);
    end

    ready_mode = 0;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || lat_pending); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("err_pulses", 64'(err_seen), 64'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
